// File: rtl/mdr_result_buffer.sv
// Result buffer behind the MDR output mux: captures each operation-done edge into a FWFT FIFO.
// Define MDR_RESULT_BUF_DROPCNT_EN to build the saturating lost-capture counter behind o_drop_cnt.
package mdr_result_buffer_pkg;
    typedef logic [15:0] data_t;

    typedef enum logic [1:0] {
        NON  = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        ROOT = 2'd3
    } op_select_t;

    typedef struct packed {
        op_select_t op;
        data_t      result;
        data_t      remainder;
    } entry_t;
endpackage

module mdr_result_buffer
    import mdr_result_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  data_t                      i_result,
    input  data_t                      i_remainder,
    input  logic                       i_ready,
    input  op_select_t                 i_selector,
    input  logic                       i_out_ready,
    output logic                       o_valid,
    output op_select_t                 o_op,
    output data_t                      o_result,
    output data_t                      o_remainder,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_drop,
    output logic [CNT_W-1:0]           o_drop_cnt
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    entry_t             storage [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    logic               ready_q;
    logic               drop_q;

    logic   capture;
    logic   pop;
    logic   push;
    logic   drop_now;
    logic   full;
    entry_t head;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        capture  = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;
        drop_now = 1'b0;
        full     = (count == COUNT_W'(DEPTH));
        head     = '{op: NON, result: '0, remainder: '0};

        capture = i_ready && !ready_q && (i_selector != NON);
        pop     = (count != '0) && i_out_ready;
        // A pop at full frees the slot the same cycle, so the capture is kept.
        push     = capture && (!full || pop);
        drop_now = capture && full && !pop;

        if (count != '0) begin
            head = storage[rd_ptr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            ready_q <= i_ready;
            drop_q  <= drop_now;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately left out of reset; entries are only observable through count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            storage[wr_ptr] <= '{op: i_selector, result: i_result, remainder: i_remainder};
        end
    end

`ifdef MDR_RESULT_BUF_DROPCNT_EN
    logic [CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt_q <= '0;
        end else if (drop_now && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    assign o_drop_cnt = '0;
`endif

    assign o_valid     = (count != '0);
    assign o_op        = head.op;
    assign o_result    = head.result;
    assign o_remainder = head.remainder;
    assign o_count     = count;
    assign o_full      = full;
    assign o_drop      = drop_q;
endmodule

// File: tb/tb_mdr_result_buffer.sv
// Directed bench for mdr_result_buffer (DEPTH=4, CNT_W=2); expectations follow the
// build of MDR_RESULT_BUF_DROPCNT_EN.
module tb_mdr_result_buffer;
    import mdr_result_buffer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    data_t      result;
    data_t      remainder;
    logic       ready;
    op_select_t selector;
    logic       out_ready;
    logic       valid;
    op_select_t op;
    data_t      res_o;
    data_t      rem_o;
    logic [2:0] count;
    logic       full;
    logic       drop;
    logic [1:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    logic       last_drop;
    logic [1:0] last_drop_cnt;

    always #5 clk = ~clk;

    mdr_result_buffer #(.DEPTH(4), .CNT_W(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_result    (result),
        .i_remainder (remainder),
        .i_ready     (ready),
        .i_selector  (selector),
        .i_out_ready (out_ready),
        .o_valid     (valid),
        .o_op        (op),
        .o_result    (res_o),
        .o_remainder (rem_o),
        .o_count     (count),
        .o_full      (full),
        .o_drop      (drop),
        .o_drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_cnt(input int drops);
`ifdef MDR_RESULT_BUF_DROPCNT_EN
        return (drops > 3) ? 2'd3 : 2'(drops);
`else
        return 2'd0;
`endif
    endfunction

    // One-cycle ready pulse; records o_drop/o_drop_cnt right after the capture edge.
    task automatic pulse(input op_select_t sel, input data_t res, input data_t rem);
        selector  = sel;
        result    = res;
        remainder = rem;
        ready     = 1'b1;
        tick();
        last_drop     = drop;
        last_drop_cnt = drop_cnt;
        ready = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        result    = '0;
        remainder = '0;
        ready     = 1'b0;
        selector  = NON;
        out_ready = 1'b0;
        last_drop     = 1'b0;
        last_drop_cnt = '0;

        // Reset and idle
        do_reset();
        repeat (10) tick();
        check("idle_valid", valid, 0);
        check("idle_count", count, 0);
        check("idle_op", op, NON);
        check("idle_result", res_o, 0);
        check("idle_drop", drop, 0);

        // Single MULT capture with ready held high
        selector  = MULT;
        result    = 16'h00C8;
        remainder = 16'h0000;
        ready     = 1'b1;
        tick();
        check("mult_valid_1cyc", valid, 1);
        repeat (4) tick();
        check("mult_count", count, 1);
        check("mult_op", op, MULT);
        check("mult_result", res_o, 16'h00C8);
        check("mult_rem", rem_o, 0);
        ready = 1'b0;
        tick();
        pop_one();
        check("mult_drained", valid, 0);
        pop_one();
        check("empty_pop_ignored", count, 0);

        // Four DIV entries, a fifth is dropped
        for (int i = 1; i <= 4; i++) begin
            pulse(DIV, 16'(i), 16'(i + 4));
            if (i == 3) check("not_full_at_3", full, 0);
        end
        check("div_full", full, 1);
        check("div_count4", count, 4);
        pulse(DIV, 16'd9, 16'd0);
        check("drop_pulse", last_drop, 1);
        check("drop_cnt_1", last_drop_cnt, exp_cnt(1));
        check("drop_one_cycle", drop, 0);
        check("drop_count_kept", count, 4);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_op_%0d", i), op, DIV);
            check($sformatf("drain_res_%0d", i), res_o, 16'(i));
            check($sformatf("drain_rem_%0d", i), rem_o, 16'(i + 4));
            pop_one();
        end
        check("drain_empty", valid, 0);

        // Capture at full with a simultaneous pop
        for (int i = 0; i < 4; i++) pulse(DIV, 16'h0021 + 16'(i), 16'h0);
        selector  = ROOT;
        result    = 16'h0010;
        remainder = 16'h0000;
        ready     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("pushpop_no_drop", drop, 0);
        check("pushpop_count", count, 4);
        ready     = 1'b0;
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pp_res_%0d", i), res_o, 16'h0022 + 16'(i));
            pop_one();
        end
        check("pp_root_op", op, ROOT);
        check("pp_root_res", res_o, 16'h0010);
        pop_one();
        check("pp_empty", valid, 0);

        // Edge rule: NON never captures; selector change while high does not capture
        pulse(NON, 16'h00AA, 16'h0);
        check("non_no_capture", count, 0);
        pulse(MULT, 16'h0055, 16'h0);
        selector = MULT;
        result   = 16'h0077;
        ready    = 1'b1;
        tick();
        check("second_edge_capture", count, 2);
        selector = DIV;
        tick();
        check("sel_change_no_capture", count, 2);

        // Reset mid-stream with ready held high
        selector = MULT;
        rst      = 1'b1;
        tick();
        check("rst_discard", count, 0);
        check("rst_valid", valid, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_capture", count, 1);
        check("post_rst_res", res_o, 16'h0077);
        tick();
        check("post_rst_level", count, 1);
        ready = 1'b0;
        tick();

        // Drop counter saturation
        do_reset();
        tick();
        check("cnt_after_rst", drop_cnt, 0);
        for (int i = 0; i < 4; i++) pulse(ROOT, 16'(i), 16'h0);
        for (int k = 1; k <= 6; k++) begin
            pulse(MULT, 16'h00EE, 16'h0);
            check($sformatf("sat_drop_%0d", k), last_drop, 1);
            check($sformatf("sat_cnt_%0d", k), last_drop_cnt, exp_cnt(k));
        end
        check("sat_head_kept", res_o, 0);
        check("sat_count", count, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
